// File: rtl/ecc12_pkg.sv
// Shared definitions for the 12-bit FIFO ECC path.
// Parity function is common to the write encoder and read checker.
package ecc12_pkg;

  localparam int DATA_W = 12;
  localparam int PAR_W  = 6;
  localparam int CW_W   = 18;

  typedef enum logic [1:0] {
    INJ_NONE   = 2'b00,
    INJ_SINGLE = 2'b01,
    INJ_DOUBLE = 2'b10,
    INJ_RSVD   = 2'b11
  } inj_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } inj_state_e;

  function automatic logic [PAR_W-1:0] ecc12_parity(
    input logic [DATA_W-1:0] d
  );
    logic [PAR_W-1:0] p;
    p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[11];
    p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
    p[2] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
    p[3] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
    p[4] = d[11];
    p[5] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11];
    return p;
  endfunction

endpackage

// File: rtl/ecc_skid_buf.sv
// Two-entry valid/ready skid buffer with a registered ready.
// Ready means the skid slot is empty, so accepts never need it.
module ecc_skid_buf #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q;
  logic         out_valid_d;
  logic         skid_valid_q;
  logic         skid_valid_d;
  logic         in_ready_q;
  logic         in_ready_d;
  logic [W-1:0] out_data_q;
  logic [W-1:0] out_data_d;
  logic [W-1:0] skid_data_q;
  logic [W-1:0] skid_data_d;
  logic         acc;
  logic         out_free;

  always_comb begin
    acc          = in_valid & in_ready_q;
    out_free     = ~out_valid_q | out_ready;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (acc) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (acc) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/ecc_12_wr_enc.sv
// Write-side ECC encoder: parity generation, one-shot error
// injection and a saturating word counter ahead of FIFO storage.
module ecc_12_wr_enc
  import ecc12_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_W,
  parameter int PARITY_WIDTH = PAR_W,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [PARITY_WIDTH-1:0] m_parity,
  input  logic                    inj_arm,
  input  logic [1:0]              inj_mode,
  input  logic [4:0]              inj_pos,
  output logic                    inj_busy,
  output logic                    inj_err,
  input  logic                    cnt_clr,
  output logic [CNT_WIDTH-1:0]    word_cnt
);

  inj_state_e          state_q;
  inj_state_e          state_d;
  inj_mode_e           mode_q;
  inj_mode_e           mode_d;
  logic [4:0]          pos_q;
  logic [4:0]          pos_d;
  logic [4:0]          pos2;
  logic                inj_err_q;
  logic                inj_err_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                acc;
  logic                pos_ok;
  logic                mode_ok;
  logic                arm_ok;
  logic [CW_W-1:0]     flip;
  logic [CW_W-1:0]     cw_in;
  logic [CW_W-1:0]     cw_out;

  always_comb begin
    acc     = s_valid & s_ready;
    pos_ok  = inj_pos <= 5'd17;
    mode_ok = (inj_mode == INJ_SINGLE) | (inj_mode == INJ_DOUBLE);
    arm_ok  = inj_arm & pos_ok & mode_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= INJ_NONE;
      pos_q     <= '0;
      inj_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pos_q     <= pos_d;
      inj_err_q <= inj_err_d;
      cnt_q     <= cnt_d;
    end
  end

  // A new arm always wins over the return to idle on accept.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pos_d     = pos_q;
    inj_err_d = inj_arm & ~pos_ok;
    if (arm_ok) begin
      state_d = ST_ARMED;
      mode_d  = inj_mode_e'(inj_mode);
      pos_d   = inj_pos;
    end else if (state_q == ST_ARMED && acc) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    inj_busy = (state_q == ST_ARMED);
    inj_err  = inj_err_q;
  end

  always_comb begin
    pos2 = (pos_q == 5'd17) ? 5'd0 : pos_q + 5'd1;
    flip = '0;
    if (state_q == ST_ARMED) begin
      flip = CW_W'(1) << pos_q;
      if (mode_q == INJ_DOUBLE) begin
        flip = flip | (CW_W'(1) << pos2);
      end
    end
    cw_in = {ecc12_parity(s_data), s_data} ^ flip;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (acc && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  ecc_skid_buf #(
    .W(CW_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s_valid),
    .in_ready (s_ready),
    .in_data  (cw_in),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data (cw_out)
  );

  assign m_data   = cw_out[DATA_WIDTH-1:0];
  assign m_parity = cw_out[CW_W-1:DATA_WIDTH];
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_ecc_12_wr_enc.sv
// Self-checking bench for ecc_12_wr_enc with a queue-based
// reference model of codewords, injection and the word counter.
module tb_ecc_12_wr_enc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [11:0] m_data;
  logic [5:0]  m_parity;
  logic        inj_arm;
  logic [1:0]  inj_mode;
  logic [4:0]  inj_pos;
  logic        inj_busy;
  logic        inj_err;
  logic        cnt_clr;
  logic [15:0] word_cnt;

  always #5 clk = ~clk;

  ecc_12_wr_enc dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_parity(m_parity),
    .inj_arm (inj_arm),
    .inj_mode(inj_mode),
    .inj_pos (inj_pos),
    .inj_busy(inj_busy),
    .inj_err (inj_err),
    .cnt_clr (cnt_clr),
    .word_cnt(word_cnt)
  );

  // Data-bit membership of each check bit.
  localparam logic [11:0] PM [6] = '{
    12'hD5B, 12'h66D, 12'h78E, 12'h7F0, 12'h800, 12'hCB7
  };

  int          checks = 0;
  int          errors = 0;
  logic [17:0] q[$];
  bit          r_armed;
  int          r_mode;
  int          r_pos;
  int          r_cnt;
  bit          r_err;

  function automatic logic [5:0] ref_par(input logic [11:0] d);
    logic [5:0] p;
    for (int k = 0; k < 6; k++) p[k] = ^(d & PM[k]);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    r_armed = 0;
    r_mode  = 0;
    r_pos   = 0;
    r_cnt   = 0;
    r_err   = 0;
  endtask

  task automatic tick();
    bit          acc;
    bit          pop;
    logic [17:0] cw;
    acc = s_valid && s_ready;
    pop = m_valid && m_ready;
    if (pop) begin
      chk("pop_has_word", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        chk("m_data", m_data, q[0][11:0]);
        chk("m_parity", m_parity, q[0][17:12]);
        void'(q.pop_front());
      end
    end
    if (acc) begin
      cw = {ref_par(s_data), s_data};
      if (r_armed) begin
        cw[r_pos] = ~cw[r_pos];
        if (r_mode == 2) cw[(r_pos + 1) % 18] = ~cw[(r_pos + 1) % 18];
        r_armed = 0;
      end
      q.push_back(cw);
    end
    r_err = inj_arm && (inj_pos > 17);
    if (inj_arm && inj_pos <= 17 && (inj_mode == 1 || inj_mode == 2)) begin
      r_armed = 1;
      r_mode  = int'(inj_mode);
      r_pos   = int'(inj_pos);
    end
    if (cnt_clr) r_cnt = 0;
    else if (acc && r_cnt < 65535) r_cnt++;
    @(posedge clk);
    #1;
    inj_arm = 0;
    cnt_clr = 0;
    chk("m_valid", m_valid, 32'(q.size() > 0));
    chk("s_ready", s_ready, 32'(q.size() < 2));
    chk("word_cnt", word_cnt, r_cnt);
    chk("inj_busy", inj_busy, r_armed);
    chk("inj_err", inj_err, r_err);
  endtask

  logic [11:0] tp_w [4] = '{12'h000, 12'h001, 12'h800, 12'hFFF};
  logic [5:0]  tp_p [4] = '{6'h00, 6'h23, 6'h31, 6'h1E};

  initial begin
    rst_n    = 0;
    s_valid  = 0;
    s_data   = '0;
    m_ready  = 0;
    inj_arm  = 0;
    inj_mode = 0;
    inj_pos  = 0;
    cnt_clr  = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", inj_busy, 0);
    chk("rst_err", inj_err, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_parity", m_parity, 0);
    rst_n = 1;
    tick();

    // Parity vectors, back to back.
    m_ready = 1;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1;
      s_data  = tp_w[i];
      tick();
      chk("tp_parity", m_parity, tp_p[i]);
      chk("tp_data", m_data, tp_w[i]);
    end
    s_valid = 0;
    tick();
    chk("tp_cnt4", word_cnt, 4);

    // Backpressure for three cycles mid-stream.
    s_valid = 1;
    s_data  = 12'($urandom);
    tick();
    m_ready = 0;
    s_data  = 12'($urandom);
    tick();
    chk("bp_sready_low", s_ready, 0);
    s_data = 12'($urandom);
    tick();
    tick();
    m_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (s_ready) s_data = 12'($urandom);
      tick();
    end
    s_valid = 0;
    repeat (3) tick();
    chk("bp_drained", 32'(q.size()), 0);

    // Single flip at bit 3.
    inj_arm  = 1;
    inj_mode = 2'b01;
    inj_pos  = 5'd3;
    tick();
    chk("sgl_busy", inj_busy, 1);
    s_valid = 1;
    s_data  = 12'h000;
    tick();
    chk("sgl_data", m_data, 12'h008);
    chk("sgl_par", m_parity, 6'h00);
    chk("sgl_busy_off", inj_busy, 0);
    tick();
    chk("sgl_clean", m_data, 12'h000);
    s_valid = 0;
    tick();

    // Double flip wrapping 17 -> 0.
    inj_arm  = 1;
    inj_mode = 2'b10;
    inj_pos  = 5'd17;
    tick();
    s_valid = 1;
    tick();
    chk("dbl_data", m_data, 12'h001);
    chk("dbl_par", m_parity, 6'h20);
    s_valid = 0;
    tick();

    // Out-of-range position.
    inj_arm  = 1;
    inj_mode = 2'b01;
    inj_pos  = 5'd20;
    tick();
    chk("err_pulse", inj_err, 1);
    chk("err_busy", inj_busy, 0);
    tick();
    chk("err_gone", inj_err, 0);
    s_valid = 1;
    tick();
    chk("err_noflip", m_data, 12'h000);
    s_valid = 0;
    tick();

    // Random traffic with random arms and clears.
    for (int i = 0; i < 400; i++) begin
      s_valid  = 1'($urandom);
      s_data   = 12'($urandom);
      m_ready  = ($urandom_range(0, 3) != 0);
      inj_arm  = ($urandom_range(0, 9) == 0);
      inj_mode = 2'($urandom);
      inj_pos  = 5'($urandom_range(0, 20));
      cnt_clr  = ($urandom_range(0, 49) == 0);
      tick();
    end
    s_valid = 0;
    m_ready = 1;
    repeat (3) tick();

    // Counter saturation and clear priority.
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    tick();
    s_valid = 1;
    repeat (65537) begin
      s_data = 12'($urandom);
      tick();
    end
    chk("sat_cnt", word_cnt, 16'hFFFF);
    cnt_clr = 1;
    tick();
    chk("clr_cnt", word_cnt, 0);
    tick();
    chk("clr_then_inc", word_cnt, 1);

    // Reset during backpressure with an armed injection.
    m_ready  = 0;
    inj_arm  = 1;
    inj_mode = 2'b01;
    inj_pos  = 5'd5;
    tick();
    tick();
    tick();
    rst_n = 0;
    model_reset();
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_busy", inj_busy, 0);
    chk("mid_rst_cnt", word_cnt, 0);
    s_valid = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_12_wr_enc.md
Name: ecc_12_wr_enc

Overview:
- Write-side ECC encoder for the FIFO ECC path.
- Accepts 12-bit data words over a valid/ready stream and generates the 6 check bits.
- Presents a registered 18-bit codeword (data plus parity) to the FIFO storage write port.
- Provides armed one-shot single/double-bit error injection and a word counter, so the read-side checker can be exercised in silicon and simulation.

Parameters:
- DATA_WIDTH, 12, data bits per word (fixed for this parity matrix)
- PARITY_WIDTH, 6, check bits per word
- CNT_WIDTH, 16, width of the accepted-word counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  upstream word valid
- s_ready  out  1  upstream ready
- s_data  in  12  upstream data
- m_valid  out  1  codeword valid to storage
- m_ready  in  1  storage accepts codeword
- m_data  out  12  data field (after injection)
- m_parity  out  6  parity field (after injection)
- inj_arm  in  1  one-cycle pulse: arm injection for the next accepted word
- inj_mode  in  2  00 none, 01 single flip, 10 double flip, 11 reserved (treated as 00)
- inj_pos  in  5  codeword bit index: 0..11 data, 12..17 parity
- inj_busy  out  1  injection armed, not yet applied
- inj_err  out  1  one-cycle pulse: arm rejected (inj_pos > 17)
- cnt_clr  in  1  synchronous clear of word_cnt
- word_cnt  out  16  accepted words, saturating at all-ones

Behaviour:
- Reset (async, rst_n low): m_valid=0, s_ready=0, skid buffer empty, inj_busy=0, inj_err=0, word_cnt=0, m_data=0, m_parity=0. s_ready rises in the first cycle after reset release.
- Parity, XOR reduction over data bits:
  - p0=d0^d1^d3^d4^d6^d8^d10^d11
  - p1=d0^d2^d3^d5^d6^d9^d10
  - p2=d1^d2^d3^d7^d8^d9^d10
  - p3=d4^d5^d6^d7^d8^d9^d10
  - p4=d11
  - p5=d0^d1^d2^d4^d5^d7^d10^d11
- Pipeline:
  - Two-entry skid buffer: main output register plus one skid register.
  - Encode and injection are applied at acceptance (s_valid&s_ready), so both registers hold final codewords.
  - Latency: 1 cycle from accept to m_valid.
  - Throughput: 1 word/cycle while m_ready=1.
  - s_ready is registered and equals "skid empty".
  - When m_ready=0 with the output full, the next accepted word goes to skid and s_ready drops the following cycle.
  - When the output drains, skid moves to output and s_ready returns.
  - m_data/m_parity stay stable while m_valid=1 and m_ready=0.
  - Word order is preserved.
- Injection FSM, states IDLE and ARMED:
  - IDLE: inj_arm=1 with inj_pos<=17 and mode 01/10 latches mode and pos, then goes to ARMED.
  - inj_pos>17: stays IDLE and pulses inj_err for 1 cycle.
  - Mode 00/11: arm ignored.
  - ARMED: the next accepted word has the codeword bit inj_pos inverted. In double mode, bit (inj_pos+1) is also inverted, with 17 wrapping to 0. The FSM then returns to IDLE.
  - inj_arm in ARMED re-latches mode and pos (last write wins).
  - inj_arm in the same cycle as an accept in IDLE does not affect that word; it applies to the next one.
  - inj_arm in ARMED in the same cycle as an accept: the old settings apply to the current word, and the new settings re-arm for the next word.
  - inj_busy=1 exactly in ARMED.
- word_cnt:
  - Increments on each accept and saturates at 16'hFFFF.
  - cnt_clr has priority over the same-cycle increment.
- Reset mid-transfer discards buffered words and any armed injection.

Decomposition:
- Shared package ecc12_pkg holds:
  - DATA_W=12, PAR_W=6, CW_W=18
  - inj_mode encodings
  - function ecc12_parity(d) implementing the matrix above; the read-side checker uses the same function.
- One sub-module ecc_skid_buf, a generic 2-entry valid/ready skid buffer of width CW_W. Encode, injection FSM and counter stay in the top level.

Test Plan:
- Reset, then stream 12'h000, 12'h001, 12'h800, 12'hFFF with m_ready=1 -> m_parity 6'h00, 6'h23, 6'h31, 6'h1E on consecutive cycles, 1-cycle latency; word_cnt=4.
- Backpressure: m_ready=0 for 3 cycles during a stream -> s_ready low after the skid fills, no word lost or duplicated, order preserved.
- Single injection: arm mode 01, pos 3, then send 12'h000 -> m_data=12'h008, m_parity=6'h00; the next word is clean; inj_busy drops after the accept.
- Double injection with wrap: mode 10, pos 17, data 12'h000 -> m_data=12'h001, m_parity=6'h20.
- Arm with pos 20 -> inj_err pulses 1 cycle, inj_busy stays 0, no flips applied.
- word_cnt preloaded near saturation by sending 65535+2 words -> holds 16'hFFFF; cnt_clr with a simultaneous accept -> 0; assert rst_n mid-backpressure -> m_valid=0 immediately.
